rec_play_sequencer: RTL

Top-level record/playback controller for the voice-recorder datapath. It sequences packet-based transfers between the audio sample stream and the serial memory interface: it opens one 32-byte packet per memory page, moves one byte per audio sample tick, closes the packet, and advances the page address. It owns the page/byte position formerly kept by a standalone counter and drives the memory interface's command, write and read handshakes.

---
 rtl/rec_play_sequencer_pkg.sv | 24 ++
 rtl/rec_play_sequencer_if.sv | 31 +++
 rtl/rec_play_sequencer_page_counter.sv | 30 +++
 rtl/rec_play_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rec_play_sequencer_pkg.sv
// Shared types and constants for the record/playback sequencer.
// Page addresses are {ADDR_MSB, page, 5'b0}.
package rec_play_sequencer_pkg;

    localparam int   PAGE_W            = 10;
    localparam int   BYTE_W            = 5;
    localparam int   ADDR_W            = 1 + PAGE_W + BYTE_W;
    localparam logic ADDR_MSB          = 1'b1;
    localparam int   DEFAULT_LAST_PAGE = 936;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REC_CMD   = 3'd1,
        REC_DATA  = 3'd2,
        PLAY_CMD  = 3'd3,
        PLAY_DATA = 3'd4,
        WAIT_DONE = 3'd5
    } state_t;

    function automatic logic [ADDR_W-1:0] page_addr(input logic [PAGE_W-1:0] page);
        return {ADDR_MSB, page, {BYTE_W{1'b0}}};
    endfunction

endpackage

// File: rtl/rec_play_sequencer_if.sv
// Packet handshake bundle between the sequencer (master) and the serial
// memory interface (slave).
interface rec_play_sequencer_if;
    import rec_play_sequencer_pkg::*;

    logic              mem_cmd_valid;
    logic              mem_cmd_write;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_cmd_ready;
    logic              mem_wvalid;
    logic [7:0]        mem_wdata;
    logic              mem_wready;
    logic              mem_rreq;
    logic              mem_rvalid;
    logic [7:0]        mem_rdata;
    logic              mem_done;
    logic              mem_abort;

    modport master (
        output mem_cmd_valid, mem_cmd_write, mem_addr, mem_wvalid, mem_wdata,
               mem_rreq, mem_abort,
        input  mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata, mem_done
    );

    modport slave (
        input  mem_cmd_valid, mem_cmd_write, mem_addr, mem_wvalid, mem_wdata,
               mem_rreq, mem_abort,
        output mem_cmd_ready, mem_wready, mem_rvalid, mem_rdata, mem_done
    );

endinterface

// File: rtl/rec_play_sequencer_page_counter.sv
// Memory page position for the sequencer; clear wins over increment.
module rec_play_sequencer_page_counter
    import rec_play_sequencer_pkg::*;
#(
    parameter int LAST_PAGE = DEFAULT_LAST_PAGE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              inc,
    output logic [PAGE_W-1:0] page,
    output logic              is_last
);

    logic [PAGE_W-1:0] page_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page_reg <= '0;
        end else if (clr) begin
            page_reg <= '0;
        end else if (inc) begin
            page_reg <= page_reg + PAGE_W'(1);
        end
    end

    assign page    = page_reg;
    assign is_last = (page_reg == PAGE_W'(LAST_PAGE));

endmodule

// File: rtl/rec_play_sequencer.sv
// Record/playback controller: one 32-byte packet per memory page, one byte
// per sample tick, with stop/restart aborts and sticky status flags.
module rec_play_sequencer
    import rec_play_sequencer_pkg::*;
#(
    parameter int LAST_PAGE    = DEFAULT_LAST_PAGE,
    parameter int PACKET_BYTES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rec_butt,
    input  logic                 play_butt,
    input  logic                 stop_butt,
    input  logic                 sample_tick,
    input  logic [7:0]           sample_in,
    rec_play_sequencer_if.master mem,
    output logic [7:0]           audio_out,
    output logic                 audio_valid,
    output logic [BYTE_W-1:0]    byte_idx,
    output logic                 recording,
    output logic                 playing,
    output logic                 rec_full,
    output logic                 overrun,
    output logic                 underrun
);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(PACKET_BYTES - 1);

    state_t            state_reg, state_next;
    logic [BYTE_W-1:0] byte_idx_reg, byte_idx_next;
    logic              rec_mode_reg, rec_mode_next;
    logic              cmd_valid_reg, cmd_valid_next;
    logic              wvalid_reg, wvalid_next;
    logic [7:0]        wdata_reg, wdata_next;
    logic              rreq_reg, rreq_next;
    logic              abort_reg, abort_next;
    logic [7:0]        audio_out_reg, audio_out_next;
    logic              audio_valid_reg, audio_valid_next;
    logic              recording_reg, recording_next;
    logic              playing_reg, playing_next;
    logic              rec_full_reg, rec_full_next;
    logic              overrun_reg, overrun_next;
    logic              underrun_reg, underrun_next;

    logic              page_clr, page_inc, page_is_last;
    logic [PAGE_W-1:0] page;
    logic              start, start_rec;

    rec_play_sequencer_page_counter #(
        .LAST_PAGE (LAST_PAGE)
    ) u_page_counter (
        .clk     (clk),
        .reset   (reset),
        .clr     (page_clr),
        .inc     (page_inc),
        .page    (page),
        .is_last (page_is_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            byte_idx_reg    <= '0;
            rec_mode_reg    <= 1'b0;
            cmd_valid_reg   <= 1'b0;
            wvalid_reg      <= 1'b0;
            wdata_reg       <= 8'h00;
            rreq_reg        <= 1'b0;
            abort_reg       <= 1'b0;
            audio_out_reg   <= 8'h00;
            audio_valid_reg <= 1'b0;
            recording_reg   <= 1'b0;
            playing_reg     <= 1'b0;
            rec_full_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            byte_idx_reg    <= byte_idx_next;
            rec_mode_reg    <= rec_mode_next;
            cmd_valid_reg   <= cmd_valid_next;
            wvalid_reg      <= wvalid_next;
            wdata_reg       <= wdata_next;
            rreq_reg        <= rreq_next;
            abort_reg       <= abort_next;
            audio_out_reg   <= audio_out_next;
            audio_valid_reg <= audio_valid_next;
            recording_reg   <= recording_next;
            playing_reg     <= playing_next;
            rec_full_reg    <= rec_full_next;
            overrun_reg     <= overrun_next;
            underrun_reg    <= underrun_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        byte_idx_next    = byte_idx_reg;
        rec_mode_next    = rec_mode_reg;
        wvalid_next      = wvalid_reg;
        wdata_next       = wdata_reg;
        rreq_next        = rreq_reg;
        abort_next       = 1'b0;
        audio_out_next   = audio_out_reg;
        audio_valid_next = 1'b0;
        rec_full_next    = rec_full_reg;
        overrun_next     = overrun_reg;
        underrun_next    = underrun_reg;
        page_clr         = 1'b0;
        page_inc         = 1'b0;
        start            = 1'b0;
        start_rec        = 1'b0;

        // Buttons override every datapath event in the same cycle.
        if (state_reg == IDLE) begin
            start     = rec_butt | play_butt;
            start_rec = rec_butt;
        end else if (stop_butt) begin
            abort_next    = 1'b1;
            state_next    = IDLE;
            page_clr      = 1'b1;
            byte_idx_next = '0;
            wvalid_next   = 1'b0;
            rreq_next     = 1'b0;
        end else if (rec_butt | play_butt) begin
            abort_next = 1'b1;
            start      = 1'b1;
            start_rec  = rec_butt;
        end else begin
            case (state_reg)
                REC_CMD, PLAY_CMD: begin
                    if (cmd_valid_reg && mem.mem_cmd_ready) begin
                        state_next    = (state_reg == REC_CMD) ? REC_DATA : PLAY_DATA;
                        byte_idx_next = '0;
                    end
                end
                REC_DATA: begin
                    if (sample_tick && wvalid_reg) begin
                        overrun_next = 1'b1;
                    end else if (sample_tick) begin
                        wvalid_next = 1'b1;
                        wdata_next  = sample_in;
                    end
                    if (wvalid_reg && mem.mem_wready) begin
                        wvalid_next = 1'b0;
                        if (byte_idx_reg == LAST_BYTE) begin
                            byte_idx_next = '0;
                            state_next    = WAIT_DONE;
                        end else begin
                            byte_idx_next = byte_idx_reg + BYTE_W'(1);
                        end
                    end
                end
                PLAY_DATA: begin
                    if (sample_tick && rreq_reg) begin
                        underrun_next = 1'b1;
                    end else if (sample_tick) begin
                        rreq_next = 1'b1;
                    end
                    if (rreq_reg && mem.mem_rvalid) begin
                        rreq_next        = 1'b0;
                        audio_out_next   = mem.mem_rdata;
                        audio_valid_next = 1'b1;
                        if (byte_idx_reg == LAST_BYTE) begin
                            byte_idx_next = '0;
                            state_next    = WAIT_DONE;
                        end else begin
                            byte_idx_next = byte_idx_reg + BYTE_W'(1);
                        end
                    end
                end
                WAIT_DONE: begin
                    if (mem.mem_done) begin
                        if (page_is_last) begin
                            page_clr   = 1'b1;
                            state_next = IDLE;
                            if (rec_mode_reg) begin
                                rec_full_next = 1'b1;
                            end
                        end else begin
                            page_inc   = 1'b1;
                            state_next = rec_mode_reg ? REC_CMD : PLAY_CMD;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (start) begin
            state_next    = start_rec ? REC_CMD : PLAY_CMD;
            rec_mode_next = start_rec;
            page_clr      = 1'b1;
            byte_idx_next = '0;
            wvalid_next   = 1'b0;
            rreq_next     = 1'b0;
            rec_full_next = 1'b0;
            overrun_next  = 1'b0;
            underrun_next = 1'b0;
        end

        // A restart spends its abort cycle with the command request low.
        cmd_valid_next = ((state_next == REC_CMD) || (state_next == PLAY_CMD)) && !abort_next;
        recording_next = (state_next != IDLE) && rec_mode_next;
        playing_next   = (state_next != IDLE) && !rec_mode_next;
    end

    assign mem.mem_cmd_valid = cmd_valid_reg;
    assign mem.mem_cmd_write = rec_mode_reg;
    assign mem.mem_addr      = page_addr(page);
    assign mem.mem_wvalid    = wvalid_reg;
    assign mem.mem_wdata     = wdata_reg;
    assign mem.mem_rreq      = rreq_reg;
    assign mem.mem_abort     = abort_reg;
    assign audio_out         = audio_out_reg;
    assign audio_valid       = audio_valid_reg;
    assign byte_idx          = byte_idx_reg;
    assign recording         = recording_reg;
    assign playing           = playing_reg;
    assign rec_full          = rec_full_reg;
    assign overrun           = overrun_reg;
    assign underrun          = underrun_reg;

endmodule
